// File: rtl/gpu_draw_pkg.sv
// Shared draw-path types: sequencer state encoding and edge-index helpers.
package gpu_draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_MIN_SCAN = 3'd2,
        ST_DRAW     = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_e;

    localparam int EDGE_IDX_W = 8;

    typedef logic [EDGE_IDX_W-1:0] edge_idx_t;

    typedef struct packed {
        edge_idx_t src;
        edge_idx_t dst;
    } edge_pair_t;

    localparam edge_idx_t EDGE_ONE   = edge_idx_t'(1);
    localparam edge_idx_t EDGE_TWO   = edge_idx_t'(2);
    localparam edge_idx_t EDGE_THREE = edge_idx_t'(3);

    // Edge e runs e -> e+1, wrapping back to vertex 0 for the closing edge.
    function automatic edge_pair_t edge_pair(input edge_idx_t e, input edge_idx_t n);
        edge_pair_t p;
        p.src = e;
        p.dst = (e + EDGE_ONE == n) ? '0 : e + EDGE_ONE;
        return p;
    endfunction

    function automatic edge_idx_t edge_total(input edge_idx_t n, input logic closed);
        if (n < EDGE_TWO) return '0;
        if (closed && n >= EDGE_THREE) return n;
        return n - EDGE_ONE;
    endfunction

endpackage

// File: rtl/vertex_min_scan.sv
// Bounding-box origin tracker: preloads from vertex 0, then folds in one vertex per cycle.
module vertex_min_scan #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic               scan_en,
    input  logic [COORD_W-1:0] cand_x,
    input  logic [COORD_W-1:0] cand_y,
    output logic [COORD_W-1:0] min_x,
    output logic [COORD_W-1:0] min_y
);

    logic [COORD_W-1:0] min_x_q, min_x_d;
    logic [COORD_W-1:0] min_y_q, min_y_d;

    always_comb begin
        min_x_d = min_x_q;
        min_y_d = min_y_q;
        if (load) begin
            min_x_d = load_x;
            min_y_d = load_y;
        end else if (scan_en) begin
            // x and y minima are independent; they may come from different vertices
            if (cand_x < min_x_q) min_x_d = cand_x;
            if (cand_y < min_y_q) min_y_d = cand_y;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            min_x_q <= '0;
            min_y_q <= '0;
        end else begin
            min_x_q <= min_x_d;
            min_y_q <= min_y_d;
        end
    end

    assign min_x = min_x_q;
    assign min_y = min_y_q;

endmodule

// File: rtl/polygon_edge_sequencer.sv
// Walks the edges of a latched polygon/polyline and hands them, origin-relative,
// one at a time to a line drawer.
module polygon_edge_sequencer
    import gpu_draw_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int MAX_VERTS = 4,
    parameter int CNT_W     = $clog2(MAX_VERTS + 1)
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             seq_en,
    input  logic [CNT_W-1:0]                 vert_count,
    input  logic                             closed,
    input  logic [2*COORD_W*MAX_VERTS-1:0]   coordinates,
    input  logic                             draw_done,
    output logic [COORD_W-1:0]               x0,
    output logic [COORD_W-1:0]               y0,
    output logic [COORD_W-1:0]               x1,
    output logic [COORD_W-1:0]               y1,
    output logic                             draw_en,
    output logic [COORD_W-1:0]               min_x,
    output logic [COORD_W-1:0]               min_y,
    output logic                             busy,
    output logic                             seq_done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VERTS);

    seq_state_e                         state_q, state_d;
    logic [2*COORD_W*MAX_VERTS-1:0]     coords_q, coords_d;
    logic                               closed_q, closed_d;
    edge_idx_t                          n_q, n_d;
    edge_idx_t                          scan_q, scan_d;
    edge_idx_t                          edge_q, edge_d;

    logic [CNT_W-1:0]                   cnt_clamped;
    edge_idx_t                          n_in;
    edge_idx_t                          e_total;
    edge_pair_t                         cur_edge;
    logic [COORD_W-1:0]                 vx [MAX_VERTS];
    logic [COORD_W-1:0]                 vy [MAX_VERTS];
    logic [COORD_W-1:0]                 scan_x, scan_y, ax, ay, bx, by;
    logic                               min_load, min_scan_en;

    for (genvar k = 0; k < MAX_VERTS; k++) begin : g_vert
        assign vx[k] = coords_q[2*k*COORD_W +: COORD_W];
        assign vy[k] = coords_q[(2*k+1)*COORD_W +: COORD_W];
    end

    assign cnt_clamped = (vert_count > MAX_CNT) ? MAX_CNT : vert_count;
    assign n_in        = edge_idx_t'(cnt_clamped);
    assign e_total     = edge_total(n_q, closed_q);
    assign cur_edge    = edge_pair(edge_q, n_q);

    always_comb begin
        scan_x = '0;
        scan_y = '0;
        ax     = '0;
        ay     = '0;
        bx     = '0;
        by     = '0;
        for (int k = 0; k < MAX_VERTS; k++) begin
            if (edge_idx_t'(k) == scan_q) begin
                scan_x = vx[k];
                scan_y = vy[k];
            end
            if (edge_idx_t'(k) == cur_edge.src) begin
                ax = vx[k];
                ay = vy[k];
            end
            if (edge_idx_t'(k) == cur_edge.dst) begin
                bx = vx[k];
                by = vy[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        coords_d    = coords_q;
        closed_d    = closed_q;
        n_d         = n_q;
        scan_d      = scan_q;
        edge_d      = edge_q;
        min_load    = 1'b0;
        min_scan_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (seq_en) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                coords_d = coordinates;
                closed_d = closed;
                n_d      = n_in;
                scan_d   = '0;
                edge_d   = '0;
                min_load = 1'b1;
                // A lone vertex still gets its one scan cycle; only an empty list skips it
                state_d  = (n_in == '0) ? ST_DONE : ST_MIN_SCAN;
            end
            ST_MIN_SCAN: begin
                min_scan_en = 1'b1;
                scan_d      = scan_q + EDGE_ONE;
                if (scan_q == n_q - EDGE_ONE)
                    state_d = (n_q < EDGE_TWO) ? ST_DONE : ST_DRAW;
            end
            ST_DRAW: begin
                if (draw_done)
                    state_d = (edge_q == e_total - EDGE_ONE) ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                edge_d  = edge_q + EDGE_ONE;
                state_d = ST_DRAW;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            coords_q <= '0;
            closed_q <= 1'b0;
            n_q      <= '0;
            scan_q   <= '0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            coords_q <= coords_d;
            closed_q <= closed_d;
            n_q      <= n_d;
            scan_q   <= scan_d;
            edge_q   <= edge_d;
        end
    end

    vertex_min_scan #(
        .COORD_W (COORD_W)
    ) u_min_scan (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (min_load),
        .load_x  (coordinates[COORD_W-1:0]),
        .load_y  (coordinates[2*COORD_W-1:COORD_W]),
        .scan_en (min_scan_en),
        .cand_x  (scan_x),
        .cand_y  (scan_y),
        .min_x   (min_x),
        .min_y   (min_y)
    );

    assign draw_en  = (state_q == ST_DRAW);
    assign busy     = (state_q != ST_IDLE);
    assign seq_done = (state_q == ST_DONE);

    // The min is never above any latched vertex, so these differences cannot wrap
    assign x0 = draw_en ? ax - min_x : '0;
    assign y0 = draw_en ? ay - min_y : '0;
    assign x1 = draw_en ? bx - min_x : '0;
    assign y1 = draw_en ? by - min_y : '0;

endmodule

// File: tb/tb_polygon_edge_sequencer.sv
// Scoreboard bench: expected edges are queued from a reference model at start, popped as the DUT draws.
module tb_polygon_edge_sequencer;

    logic        clk;
    logic        n_rst;
    logic        seq_en;
    logic [2:0]  vert_count;
    logic        closed;
    logic [63:0] coordinates;
    logic        draw_done;
    logic [7:0]  x0, y0, x1, y1, min_x, min_y;
    logic        draw_en, busy, seq_done;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    polygon_edge_sequencer #(
        .COORD_W   (8),
        .MAX_VERTS (4),
        .CNT_W     (3)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .seq_en      (seq_en),
        .vert_count  (vert_count),
        .closed      (closed),
        .coordinates (coordinates),
        .draw_done   (draw_done),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .draw_en     (draw_en),
        .min_x       (min_x),
        .min_y       (min_y),
        .busy        (busy),
        .seq_done    (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [7:0] ax, ay, bx, by, cx, cy, dx, dy);
        return {dy, dx, cy, cx, by, bx, ay, ax};
    endfunction

    // Reference model: clamp, bounding-box min, edge list.
    task automatic build_exp(input logic [2:0] vc, input logic cl, input logic [63:0] crd,
                             output int n, output int ne, output logic [7:0] mx, output logic [7:0] my);
        logic [7:0] vx[4];
        logic [7:0] vy[4];
        for (int k = 0; k < 4; k++) begin
            vx[k] = crd[16*k +: 8];
            vy[k] = crd[16*k+8 +: 8];
        end
        n  = (int'(vc) > 4) ? 4 : int'(vc);
        mx = vx[0];
        my = vy[0];
        for (int k = 1; k < n; k++) begin
            if (vx[k] < mx) mx = vx[k];
            if (vy[k] < my) my = vy[k];
        end
        ne = (n < 2) ? 0 : ((cl && n >= 3) ? n : n - 1);
        for (int e = 0; e < ne; e++) begin
            int b;
            b = (e + 1 == n) ? 0 : e + 1;
            exp_q.push_back({vx[e] - mx, vy[e] - my, vx[b] - mx, vy[b] - my});
        end
    endtask

    task automatic run_seq(input logic [2:0] vc, input logic cl, input logic [63:0] crd,
                           input int abort_edge, input bit scramble, input bit en_with_done);
        int n, ne, cyc, hold, gap, eidx;
        logic [7:0] mx, my;
        bit in_draw, fin, dd;
        exp_q.delete();
        build_exp(vc, cl, crd, n, ne, mx, my);
        vert_count  = vc;
        closed      = cl;
        coordinates = crd;
        seq_en      = 1'b1;
        cyc = 0; hold = 0; gap = 0; eidx = 0;
        in_draw = 0; fin = 0; dd = 0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_start", busy, 1);
            if (seq_done) begin
                chk("left_edges", exp_q.size(), 0);
                chk("min_x", min_x, mx);
                chk("min_y", min_y, my);
                if (ne == 0) chk("short_lat", cyc, (n == 0) ? 2 : 3);
                else         chk("done_lat", dd, 1);
                fin = 1;
            end
            if (draw_en) begin
                if (!in_draw) begin
                    if (eidx > 0) chk("gap_len", gap, 1);
                    in_draw = 1;
                    hold = $urandom_range(0, 2);
                    if (scramble) begin
                        coordinates = {$urandom, $urandom};
                        closed      = ~closed;
                        vert_count  = 3'($urandom_range(0, 7));
                    end
                end
                if (exp_q.size() == 0) chk("extra_edge", 1, 0);
                else chk($sformatf("edge%0d", eidx), {x0, y0, x1, y1}, exp_q[0]);
                if (eidx == abort_edge) begin
                    n_rst = 1'b0;
                    #1;
                    chk("rst_outs", {x0, y0, x1, y1, draw_en, busy, seq_done, min_x, min_y}, 0);
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_no_done", {seq_done, busy, draw_en}, 0);
                    end
                    draw_done = 1'b0;
                    seq_en    = 1'b0;
                    n_rst     = 1'b1;
                    exp_q.delete();
                    return;
                end
            end else begin
                chk("idle_xy", {x0, y0, x1, y1}, 0);
                if (in_draw) begin
                    in_draw = 0;
                    gap = 0;
                end
                gap++;
            end
            if (cyc == 1) seq_en = 1'b0;
            if (dd) begin
                draw_done = 1'b0;
                seq_en    = 1'b0;
                dd        = 0;
            end else if (draw_en) begin
                if (hold == 0) begin
                    draw_done = 1'b1;
                    dd = 1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    eidx++;
                    if (en_with_done) seq_en = 1'b1;
                end else begin
                    hold--;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse", {seq_done, busy}, 0);
    endtask

    initial begin
        n_rst       = 1'b0;
        seq_en      = 1'b0;
        vert_count  = '0;
        closed      = 1'b0;
        coordinates = '0;
        draw_done   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {x0, y0, x1, y1, draw_en, busy, seq_done, min_x, min_y}, 0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {busy, draw_en, seq_done}, 0);

        // open 2-vertex line
        run_seq(3'd2, 1'b0, pack4(10, 20, 30, 5, 0, 0, 0, 0), -1, 0, 0);
        // closed triangle, then the same as an open polyline (seq_en raced with draw_done)
        run_seq(3'd3, 1'b1, pack4(5, 5, 9, 2, 3, 7, 0, 0), -1, 0, 0);
        run_seq(3'd3, 1'b0, pack4(5, 5, 9, 2, 3, 7, 0, 0), -1, 0, 1);
        // degenerate counts
        run_seq(3'd1, 1'b1, pack4(40, 50, 1, 1, 2, 2, 3, 3), -1, 0, 0);
        run_seq(3'd0, 1'b1, pack4(60, 70, 1, 1, 2, 2, 3, 3), -1, 0, 0);
        // reset during edge 1 of a closed quad, then restart cleanly
        run_seq(3'd4, 1'b1, pack4(12, 40, 50, 8, 90, 60, 20, 99), 1, 0, 0);
        run_seq(3'd4, 1'b1, pack4(12, 40, 50, 8, 90, 60, 20, 99), -1, 0, 0);
        // oversized count clamps; inputs scrambled while drawing
        run_seq(3'd7, 1'b1, pack4(100, 3, 7, 200, 255, 0, 1, 128), -1, 1, 0);
        for (int i = 0; i < 6; i++)
            run_seq(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
